uart_boot_loader: RTL and testbench

- Write-side counterpart of the BIOS ROM: receives a program image as a byte stream from the UART receiver and writes it word by word into the boot/instruction RAM.
- Holds the CPU in reset while a load is in progress.
- Validates the frame with a magic header, a length word and a checksum, and reports completion or error.

---
 rtl/uart_boot_loader.sv | 204 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image byte by byte and
// writes it word by word into the instruction RAM while holding the CPU.
module uart_boot_loader #(
    parameter int          ADDR_WIDTH = 11,
    parameter logic [31:0] MAGIC      = 32'hEFBEADDE,
    parameter int          TIMEOUT    = 100000
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [7:0]            rxData,
    input  logic                  rxValid,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]           memWriteData,
    output logic                  memWriteEnable,
    output logic                  cpuHold,
    output logic                  loadDone,
    output logic                  loadError,
    output logic [1:0]            errorCode,
    output logic [ADDR_WIDTH:0]   wordCount
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] SYNC = 2'd0;
    localparam logic [1:0] LEN  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] CSUM = 2'd3;

    localparam logic [32:0] MAX_LEN = 33'd1 << ADDR_WIDTH;

    logic [1:0]            state_q, state_d;
    logic [31:0]           shift_q, shift_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           sum_q, sum_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    logic [31:0] full;
    logic [31:0] shiftIn;
    logic        lastByte;
    logic        lenBad;
    logic        lastWord;
    logic        expired;

    assign full     = {rxData, word_q[31:8]};
    assign shiftIn  = {rxData, shift_q[31:8]};
    assign lastByte = rxValid && (idx_q == 2'd3);
    assign lenBad   = (full == 32'd0) || ({1'b0, full} > MAX_LEN);
    assign lastWord = ({1'b0, addr_q} + {{ADDR_WIDTH{1'b0}}, 1'b1}) == len_q;
    assign expired  = (state_q != SYNC) && !rxValid
                      && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        word_d  = word_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        timer_d = timer_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        count_d = count_q;

        // Address and count advance one cycle after each write
        if (we_q) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
        end

        if (state_q != SYNC) begin
            timer_d = rxValid ? '0 : timer_q + 1'b1;
            if (rxValid) begin
                word_d = full;
                idx_d  = idx_q + 2'd1;
            end
        end

        case (state_q)
            LEN: begin
                if (lastByte) begin
                    if (lenBad) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        hold_d  = 1'b0;
                        state_d = SYNC;
                        shift_d = '0;
                    end else begin
                        len_d   = full[ADDR_WIDTH:0];
                        addr_d  = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (lastByte) begin
                    we_d    = 1'b1;
                    wdata_d = full;
                    sum_d   = sum_q + full;
                    if (lastWord) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (lastByte) begin
                    if (full == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd3;
                    end
                    hold_d  = 1'b0;
                    state_d = SYNC;
                    shift_d = '0;
                end
            end
            default: begin
                if (rxValid) begin
                    shift_d = shiftIn;
                    if (shiftIn == MAGIC) begin
                        state_d = LEN;
                        hold_d  = 1'b1;
                        code_d  = 2'd0;
                        count_d = '0;
                        sum_d   = '0;
                        idx_d   = 2'd0;
                        timer_d = '0;
                        word_d  = '0;
                    end
                end
            end
        endcase

        if (expired) begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            hold_d  = 1'b0;
            state_d = SYNC;
            shift_d = '0;
            timer_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= SYNC;
            shift_q <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            timer_q <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            timer_q <= timer_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            count_q <= count_d;
        end
    end

    assign memAddress     = addr_q;
    assign memWriteData   = wdata_q;
    assign memWriteEnable = we_q;
    assign cpuHold        = hold_q;
    assign loadDone       = done_q;
    assign loadError      = err_q;
    assign errorCode      = code_q;
    assign wordCount      = count_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: frames are built from random words,
// expected writes/pulses are queued with their due cycle and checked by a monitor.
module tb_uart_boot_loader;

    localparam int          AW    = 11;
    localparam int          TO    = 16;
    localparam logic [31:0] MAGIC = 32'hEFBEADDE;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic [7:0]    rxData = 8'h00;
    logic          rxValid = 1'b0;
    logic [AW-1:0] memAddress;
    logic [31:0]   memWriteData;
    logic          memWriteEnable;
    logic          cpuHold;
    logic          loadDone;
    logic          loadError;
    logic [1:0]    errorCode;
    logic [AW:0]   wordCount;

    uart_boot_loader #(
        .ADDR_WIDTH(AW),
        .MAGIC     (MAGIC),
        .TIMEOUT   (TO)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .rxData        (rxData),
        .rxValid       (rxValid),
        .memAddress    (memAddress),
        .memWriteData  (memWriteData),
        .memWriteEnable(memWriteEnable),
        .cpuHold       (cpuHold),
        .loadDone      (loadDone),
        .loadError     (loadError),
        .errorCode     (errorCode),
        .wordCount     (wordCount)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [1:0]    code;
        int            at;
    } ev_t;

    ev_t         expq[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    int          hold_lo = 32'h7fffffff;
    int          hold_hi = 0;
    int          last_cyc = 0;
    int          gap_max = 0;
    logic [31:0] wq[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [1:0] c,
                           input int at);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.code = c;
        e.at   = at;
        expq.push_back(e);
    endtask

    // Byte is sampled at the next rising edge; record that edge's number
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rxData   = b;
        rxValid  = 1'b1;
        last_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            rxValid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            send_byte(w[8*b +: 8]);
        end
    endtask

    task automatic fill_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    task automatic frame(input logic [31:0] L, input bit force_cs,
                         input logic [31:0] cs_val);
        logic [31:0] sum;
        logic [31:0] cs;
        int          nw;
        logic [1:0]  ec;
        sum = 0;
        send_word(MAGIC);
        hold_lo = last_cyc;
        hold_hi = 32'h7fffffff;
        send_word(L);
        if (L == 0 || L > (32'd1 << AW)) begin
            push_ev(2, '0, '0, 2'd1, last_cyc);
            hold_hi = last_cyc;
            nw = 0;
            ec = 2'd1;
        end else begin
            for (int i = 0; i < int'(L); i++) begin
                send_word(wq[i]);
                push_ev(0, AW'(i), wq[i], 2'd0, last_cyc);
                sum += wq[i];
            end
            cs = force_cs ? cs_val : sum;
            send_word(cs);
            if (cs == sum) begin
                push_ev(1, '0, '0, 2'd0, last_cyc);
                ec = 2'd0;
            end else begin
                push_ev(2, '0, '0, 2'd3, last_cyc);
                ec = 2'd3;
            end
            hold_hi = last_cyc;
            nw = int'(L);
        end
        idle(4);
        check("wordCount", wordCount, nw);
        check("errorCode", errorCode, ec);
    endtask

    ev_t mon_e;
    int  nact;
    always @(negedge clock) begin
        if (mon_on) begin
            while (expq.size() > 0 && expq[0].at < cyc) begin
                mon_e = expq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: kind %0d due cycle %0d, not seen by %0d",
                         mon_e.kind, mon_e.at, cyc);
            end
            nact = int'(memWriteEnable) + int'(loadDone) + int'(loadError);
            check("single_strobe", nact <= 1, 1);
            if (nact != 0) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: we=%b done=%b err=%b code=%0d cycle %0d",
                             memWriteEnable, loadDone, loadError, errorCode, cyc);
                end else begin
                    mon_e = expq.pop_front();
                    check("event_cycle", cyc, mon_e.at);
                    case (mon_e.kind)
                        0: begin
                            check("write_strobe", memWriteEnable, 1);
                            check("write_addr", memAddress, mon_e.addr);
                            check("write_data", memWriteData, mon_e.data);
                        end
                        1: begin
                            check("done_pulse", loadDone, 1);
                            check("done_code", errorCode, 0);
                        end
                        default: begin
                            check("error_pulse", loadError, 1);
                            check("error_code", errorCode, mon_e.code);
                        end
                    endcase
                end
            end
            check("cpuHold", cpuHold, (cyc >= hold_lo && cyc < hold_hi));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_memAddress"}, memAddress, 0);
        check({tag, "_memWriteData"}, memWriteData, 0);
        check({tag, "_memWriteEnable"}, memWriteEnable, 0);
        check({tag, "_cpuHold"}, cpuHold, 0);
        check({tag, "_loadDone"}, loadDone, 0);
        check({tag, "_loadError"}, loadError, 0);
        check({tag, "_errorCode"}, errorCode, 0);
        check({tag, "_wordCount"}, wordCount, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  g;

        repeat (3) @(negedge clock);
        check_all_zero("reset");
        mon_on = 1'b1;
        resetN = 1'b1;
        idle(2);

        // Single-word frame
        wq.delete();
        wq.push_back(32'h12345678);
        frame(32'd1, 1'b0, 32'h0);

        // Three words back-to-back
        wq.delete();
        wq.push_back(32'd1);
        wq.push_back(32'd2);
        wq.push_back(32'd3);
        frame(32'd3, 1'b0, 32'h0);

        // Bad lengths
        wq.delete();
        frame(32'd0, 1'b0, 32'h0);
        frame(32'h801, 1'b0, 32'h0);

        // Wrong checksum
        wq.delete();
        wq.push_back(32'd5);
        frame(32'd1, 1'b1, 32'h0);

        // Silence after two length bytes
        send_word(MAGIC);
        hold_lo = last_cyc;
        hold_hi = 32'h7fffffff;
        send_byte(8'h02);
        send_byte(8'h00);
        push_ev(2, '0, '0, 2'd2, last_cyc + TO);
        hold_hi = last_cyc + TO;
        idle(TO + 6);
        check("timeout_wordCount", wordCount, 0);
        check("timeout_errorCode", errorCode, 2);

        // Byte arriving exactly at the expiry cycle
        send_word(MAGIC);
        hold_lo = last_cyc;
        hold_hi = 32'h7fffffff;
        send_byte(8'h01);
        send_byte(8'h00);
        idle(TO - 1);
        send_byte(8'h00);
        send_byte(8'h00);
        w = $urandom;
        send_word(w);
        push_ev(0, '0, w, 2'd0, last_cyc);
        send_word(w);
        push_ev(1, '0, '0, 2'd0, last_cyc);
        hold_hi = last_cyc;
        idle(4);
        check("rescue_wordCount", wordCount, 1);
        check("rescue_errorCode", errorCode, 0);

        // Overlapping header prefix
        send_byte(8'h11);
        send_byte(8'hDE);
        fill_words(1);
        frame(32'd1, 1'b0, 32'h0);

        // Reset in the middle of the payload
        send_word(MAGIC);
        hold_lo = last_cyc;
        hold_hi = 32'h7fffffff;
        send_word(32'd4);
        w = $urandom;
        send_word(w);
        push_ev(0, '0, w, 2'd0, last_cyc);
        send_byte(8'hA5);
        send_byte(8'h5A);
        idle(3);
        @(negedge clock);
        resetN = 1'b0;
        hold_hi = cyc + 1;
        @(negedge clock);
        check_all_zero("midreset");
        resetN = 1'b1;
        send_byte(8'h11);
        send_byte(8'hDE);
        fill_words(1);
        frame(32'd1, 1'b0, 32'h0);

        // Random frames with gaps, garbage and occasional bad checksums
        for (int k = 0; k < 12; k++) begin
            gap_max = 0;
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                g = 8'($urandom);
                if (g == 8'hEF) g = 8'h00;
                send_byte(g);
            end
            gap_max = $urandom_range(0, 3);
            fill_words($urandom_range(1, 6));
            frame(32'(wq.size()), $urandom_range(0, 3) == 0, $urandom);
        end

        // Largest accepted image
        gap_max = 0;
        fill_words(1 << AW);
        frame(32'd1 << AW, 1'b0, 32'h0);

        idle(20);
        check("pending_events", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
